// File: rtl/pwm_duty_decoder_pkg.sv
// pwm_duty_decoder_pkg: default widths and measurement FSM states
package pwm_duty_decoder_pkg;
    localparam int ADC_BITWIDTH_DEF = 4;
    localparam int CNT_BITWIDTH_DEF = 8;
    typedef enum logic {IDLE, COUNT} state_e;
endpackage

// File: rtl/pwm_restoring_divider.sv
// pwm_restoring_divider: unsigned restoring divider producing one quotient bit per clock
module pwm_restoring_divider #(
    parameter int QW = 5,
    parameter int DW = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DW+QW-2:0] dividend_i,
    input  logic [DW-1:0]    divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [QW-1:0]    quotient_o
);
    localparam int CW = $clog2(QW + 1);
    logic [DW-1:0] rem_q, rem_d, div_q, div_d, diff;
    logic [QW-1:0] shf_q, shf_d;
    logic [QW-2:0] quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d, fits;
    logic [DW:0]   trial;
    // upper dividend bits are below the divisor, so only QW steps are needed
    always_comb begin
        trial      = {rem_q, shf_q[QW-1]};
        fits       = trial >= {1'b0, div_q};
        diff       = trial[DW-1:0] - div_q;
        quotient_o = {quo_q, fits};
        done_o     = busy_q && cnt_q == CW'(1);
        busy_o     = busy_q;
        rem_d      = rem_q;
        div_d      = div_q;
        shf_d      = shf_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        if (start_i && !busy_q) begin
            rem_d  = DW'(dividend_i[DW+QW-2:QW]);
            shf_d  = dividend_i[QW-1:0];
            div_d  = divisor_i;
            quo_d  = '0;
            cnt_d  = CW'(QW);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = fits ? diff : trial[DW-1:0];
            shf_d  = shf_q << 1;
            quo_d  = quotient_o[QW-2:0];
            cnt_d  = cnt_q - CW'(1);
            busy_d = cnt_q != CW'(1);
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            div_q  <= '0;
            shf_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            div_q  <= div_d;
            shf_q  <= shf_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures PWM period/high time in enabled samples and publishes the duty value
module pwm_duty_decoder
    import pwm_duty_decoder_pkg::*;
#(
    parameter int ADC_BITWIDTH = ADC_BITWIDTH_DEF,
    parameter int CNT_BITWIDTH = CNT_BITWIDTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clk_en_i,
    input  logic                    PWM_pin_i,
    output logic [ADC_BITWIDTH-1:0] duty_value_o,
    output logic [CNT_BITWIDTH-1:0] period_value_o,
    output logic                    dataVaild_STRB_o,
    output logic                    stuck_o
);
    localparam logic [CNT_BITWIDTH-1:0] TO_CNT = {{(CNT_BITWIDTH-1){1'b1}}, 1'b0};
    state_e                  state_q, state_d;
    logic                    sync1_q, sync2_q, s_q, s_d, s_d_q, s_d_d;
    logic [CNT_BITWIDTH-1:0] period_cnt_q, period_cnt_d, high_cnt_q, high_cnt_d;
    logic [CNT_BITWIDTH-1:0] cap_period_q, cap_period_d, period_q, period_d;
    logic [ADC_BITWIDTH-1:0] duty_q, duty_d;
    logic                    stuck_q, stuck_d, strobe_q, strobe_d;
    logic                    to_pend_q, to_pend_d, to_lvl_q, to_lvl_d;
    logic                    rise, in_count, timeout, start, div_busy, div_done;
    logic [ADC_BITWIDTH:0]   quot;
    pwm_restoring_divider #(.QW(ADC_BITWIDTH + 1), .DW(CNT_BITWIDTH)) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start),
        .dividend_i ({high_cnt_q, {ADC_BITWIDTH{1'b0}}}),
        .divisor_i  (cap_period_d),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (quot)
    );
    always_comb begin
        rise         = clk_en_i & s_q & ~s_d_q;
        in_count     = state_q == COUNT;
        timeout      = in_count & clk_en_i & ~rise & (period_cnt_q == TO_CNT);
        start        = in_count & rise & ~div_busy;
        s_d          = clk_en_i ? sync2_q : s_q;
        s_d_d        = clk_en_i ? s_q : s_d_q;
        state_d      = (state_q == IDLE && rise) ? COUNT : state_q;
        cap_period_d = start ? period_cnt_q : cap_period_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        if (rise) begin
            period_cnt_d = CNT_BITWIDTH'(1);
            high_cnt_d   = CNT_BITWIDTH'(1);
        end else if (timeout) begin
            period_cnt_d = '0;
            high_cnt_d   = '0;
        end else if (in_count && clk_en_i) begin
            period_cnt_d = period_cnt_q + CNT_BITWIDTH'(1);
            high_cnt_d   = high_cnt_q + CNT_BITWIDTH'(s_q);
        end
        duty_d    = duty_q;
        period_d  = period_q;
        stuck_d   = stuck_q;
        strobe_d  = 1'b0;
        to_pend_d = 1'b0;
        to_lvl_d  = timeout ? s_q : to_lvl_q;
        // a timeout coinciding with divider completion is deferred by one cycle
        if (div_done) begin
            duty_d    = quot[ADC_BITWIDTH] ? '1 : quot[ADC_BITWIDTH-1:0];
            period_d  = cap_period_q;
            stuck_d   = 1'b0;
            strobe_d  = 1'b1;
            to_pend_d = timeout;
        end else if (timeout || to_pend_q) begin
            duty_d   = {ADC_BITWIDTH{timeout ? s_q : to_lvl_q}};
            period_d = '1;
            stuck_d  = 1'b1;
            strobe_d = 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            s_q          <= 1'b0;
            s_d_q        <= 1'b0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            cap_period_q <= '0;
            duty_q       <= '0;
            period_q     <= '0;
            stuck_q      <= 1'b0;
            strobe_q     <= 1'b0;
            to_pend_q    <= 1'b0;
            to_lvl_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= PWM_pin_i;
            sync2_q      <= sync1_q;
            s_q          <= s_d;
            s_d_q        <= s_d_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            cap_period_q <= cap_period_d;
            duty_q       <= duty_d;
            period_q     <= period_d;
            stuck_q      <= stuck_d;
            strobe_q     <= strobe_d;
            to_pend_q    <= to_pend_d;
            to_lvl_q     <= to_lvl_d;
        end
    end
    assign duty_value_o     = duty_q;
    assign period_value_o   = period_q;
    assign dataVaild_STRB_o = strobe_q;
    assign stuck_o          = stuck_q;
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: random and directed PWM stimulus against an event-level reference model
module tb_pwm_duty_decoder;
    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, pin = 1'b0;
    logic [3:0] duty;
    logic [7:0] period;
    logic       strobe, stuck;
    int checks = 0, errors = 0, cyc = 0;
    int m_s1 = 0, m_s2 = 0, m_s = 0, m_sd = 0, m_cnt = 0, m_per = 0, m_hi = 0, m_busy = -1;
    int m_duty = 0, m_period = 0, m_stuck = 0;
    int pub_d[int], pub_p[int], pub_s[int];

    always #5 clk = ~clk;

    pwm_duty_decoder dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .clk_en_i         (en),
        .PWM_pin_i        (pin),
        .duty_value_o     (duty),
        .period_value_o   (period),
        .dataVaild_STRB_o (strobe),
        .stuck_o          (stuck)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic sched(input int t, input int d, input int p, input int s);
        pub_d[t] = d;
        pub_p[t] = p;
        pub_s[t] = s;
    endtask

    // one clock: compare this cycle's outputs, then drive inputs and advance the model
    task automatic tick(input logic p, input logic e, input logic r);
        int t, rise, exp_strobe;
        @(negedge clk);
        exp_strobe = pub_d.exists(cyc) ? 1 : 0;
        if (exp_strobe == 1) begin
            m_duty = pub_d[cyc];
            m_period = pub_p[cyc];
            m_stuck = pub_s[cyc];
        end
        check("strobe", 32'(strobe), exp_strobe);
        check("duty", 32'(duty), m_duty);
        check("period", 32'(period), m_period);
        check("stuck", 32'(stuck), m_stuck);
        pin = p;
        en = e;
        rst = r;
        if (r) begin
            {m_s1, m_s2, m_s, m_sd, m_cnt, m_per, m_hi} = '0;
            {m_duty, m_period, m_stuck} = '0;
            m_busy = -1;
            pub_d.delete();
            pub_p.delete();
            pub_s.delete();
        end else begin
            if (e) begin
                rise = (m_s == 1 && m_sd == 0) ? 1 : 0;
                if (m_cnt == 0) begin
                    if (rise == 1) begin
                        m_cnt = 1;
                        m_per = 1;
                        m_hi = 1;
                    end
                end else if (rise == 1) begin
                    if (cyc > m_busy) begin
                        sched(cyc + 6, (m_per == 0 || m_hi * 16 / m_per > 15) ? 15 : m_hi * 16 / m_per, m_per, 0);
                        m_busy = cyc + 5;
                    end
                    m_per = 1;
                    m_hi = 1;
                end else if (m_per == 254) begin
                    t = pub_d.exists(cyc + 1) ? cyc + 2 : cyc + 1;
                    sched(t, m_s == 1 ? 15 : 0, 255, 1);
                    m_per = 0;
                    m_hi = 0;
                end else begin
                    m_per++;
                    m_hi += m_s;
                end
                m_sd = m_s;
                m_s = m_s2;
            end
            m_s2 = m_s1;
            m_s1 = int'(p);
        end
        cyc++;
    endtask

    task automatic pwm(input int per, input int hi, input int n, input int alt, input int glitch);
        for (int i = 0; i < n; i++)
            tick((i % per) < hi || (glitch == 1 && i % per == 21), alt == 1 ? (i % 2 == 0) : 1'b1, 1'b0);
    endtask

    task automatic spot(input string tag, input int d, input int p, input int s);
        check({tag, "_duty"}, 32'(duty), d);
        check({tag, "_period"}, 32'(period), p);
        check({tag, "_stuck"}, 32'(stuck), s);
    endtask

    initial begin
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        spot("reset", 0, 0, 0);
        pwm(20, 5, 120, 0, 0);
        spot("p20h5", 4, 20, 0);
        pwm(19, 3, 100, 0, 0);
        spot("p19h3", 2, 19, 0);
        pwm(20, 19, 100, 0, 0);
        spot("p20h19", 15, 20, 0);
        pwm(40, 10, 200, 1, 1);
        spot("half_en", 4, 20, 0);
        repeat (600) tick(1'b1, 1'b1, 1'b0);
        spot("stuck_hi", 15, 255, 1);
        repeat (600) tick(1'b0, 1'b1, 1'b0);
        spot("stuck_lo", 0, 255, 1);
        pwm(20, 5, 100, 0, 0);
        spot("unstuck", 4, 20, 0);
        pwm(4, 2, 100, 0, 0);
        spot("p4h2", 8, 4, 0);
        for (int k = 0; k < 8; k++) begin
            int per;
            per = int'($urandom_range(6, 40));
            pwm(per, int'($urandom_range(1, per - 1)), per * 6, int'($urandom_range(0, 1)), 0);
        end
        tick(1'b0, 1'b1, 1'b1);
        pwm(20, 5, 25, 0, 0);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        spot("mid_rst", 0, 0, 0);
        pwm(20, 5, 15, 0, 0);
        spot("no_strobe", 0, 0, 0);
        pwm(20, 5, 80, 0, 0);
        spot("recover", 4, 20, 0);
        repeat (10) tick(1'b0, 1'b1, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
